stream_mux: RTL and testbench

- N-channel, parametrised-width stream multiplexer with valid/ready handshakes and a registered output stage.
- Successor to the two-input combinational mux. Adds channel count, packet locking via last-beat markers, and two selection modes: externally selected, or internal round-robin arbitration.
- Sits between several producer streams and one consumer, for example DMA channels merging onto one bus port.

---
 rtl/stream_mux.sv | 153 +++++++++++++++
 tb/tb_stream_mux.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Packets are locked to one channel from first beat to last; selection is external or round-robin.
module stream_mux #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = $clog2(CHANNELS),
   parameter int MODE     = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS-1:0]       in_last,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SEL_W-1:0]          select,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_last,
   output logic [SEL_W-1:0]          out_channel,
   output logic                      out_valid,
   input  logic                      out_ready
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state_r;
   logic [SEL_W-1:0]   lock_ch_r;
   logic [SEL_W-1:0]   rr_ptr_r;
   logic [WIDTH-1:0]   out_data_r;
   logic               out_last_r;
   logic [SEL_W-1:0]   out_channel_r;
   logic               out_valid_r;

   logic               space_s;
   logic               rr_hi_vld_s;
   logic               rr_lo_vld_s;
   logic [SEL_W-1:0]   rr_hi_idx_s;
   logic [SEL_W-1:0]   rr_lo_idx_s;
   logic               rr_vld_s;
   logic [SEL_W-1:0]   rr_grant_s;
   logic               grant_vld_s;
   logic [SEL_W-1:0]   grant_s;
   logic [CHANNELS-1:0] in_ready_s;
   logic               xfer_s;
   logic [WIDTH-1:0]   sel_data_s;
   logic               sel_last_s;

   assign space_s = !out_valid_r || out_ready;

   // Round-robin search: lowest valid channel above rr_ptr wins, else lowest valid at or below it.
   always_comb begin
      rr_hi_vld_s = 1'b0;
      rr_lo_vld_s = 1'b0;
      rr_hi_idx_s = '0;
      rr_lo_idx_s = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         rr_hi_idx_s = (in_valid[i] && (i > int'(rr_ptr_r)))  ? SEL_W'(i) : rr_hi_idx_s;
         rr_hi_vld_s = rr_hi_vld_s | (in_valid[i] && (i > int'(rr_ptr_r)));
         rr_lo_idx_s = (in_valid[i] && (i <= int'(rr_ptr_r))) ? SEL_W'(i) : rr_lo_idx_s;
         rr_lo_vld_s = rr_lo_vld_s | (in_valid[i] && (i <= int'(rr_ptr_r)));
      end
      rr_vld_s   = rr_hi_vld_s | rr_lo_vld_s;
      rr_grant_s = rr_hi_vld_s ? rr_hi_idx_s : rr_lo_idx_s;
   end

   // Grant source: locked channel while a packet is open, otherwise the configured selection mode.
   always_comb begin
      if (state_r == BUSY) begin
         grant_vld_s = 1'b1;
         grant_s     = lock_ch_r;
      end else if (MODE == 1) begin
         grant_vld_s = rr_vld_s;
         grant_s     = rr_grant_s;
      end else begin
         grant_vld_s = (int'(select) < CHANNELS);
         grant_s     = select;
      end
   end

   // Per-channel ready and the data/last of the granted channel.
   always_comb begin
      in_ready_s = '0;
      sel_data_s = '0;
      sel_last_s = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         in_ready_s[i] = space_s && grant_vld_s && (grant_s == SEL_W'(i));
         sel_data_s    = (grant_s == SEL_W'(i)) ? in_data[i*WIDTH +: WIDTH] : sel_data_s;
         sel_last_s    = (grant_s == SEL_W'(i)) ? in_last[i] : sel_last_s;
      end
      xfer_s = |(in_valid & in_ready_s);
   end

   assign in_ready = in_ready_s;

   // Output register, packet-lock FSM and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         lock_ch_r     <= '0;
         rr_ptr_r      <= SEL_W'(CHANNELS - 1);
         out_data_r    <= '0;
         out_last_r    <= 1'b0;
         out_channel_r <= '0;
         out_valid_r   <= 1'b0;
      end else begin
         if (xfer_s) begin
            out_data_r    <= sel_data_s;
            out_last_r    <= sel_last_s;
            out_channel_r <= grant_s;
            out_valid_r   <= 1'b1;
         end else if (space_s) begin
            out_valid_r   <= 1'b0;
         end else begin
            out_valid_r   <= out_valid_r;
         end

         case (state_r)
            IDLE: begin
               if (xfer_s && !sel_last_s) begin
                  state_r   <= BUSY;
                  lock_ch_r <= grant_s;
               end else begin
                  state_r   <= IDLE;
               end
            end
            BUSY: begin
               if (xfer_s && sel_last_s) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= BUSY;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase

         if (xfer_s && sel_last_s) begin
            rr_ptr_r <= grant_s;
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
      end
   end

   assign out_data    = out_data_r;
   assign out_last    = out_last_r;
   assign out_channel = out_channel_r;
   assign out_valid   = out_valid_r;

endmodule

// File: tb/tb_stream_mux.sv
// Scoreboard bench for stream_mux: external-select and round-robin 4-channel instances,
// plus a 3-channel instance for the out-of-range select case.
module tb_stream_mux;

   typedef struct {
      logic [7:0] d;
      logic       l;
      logic [1:0] ch;
      int         stamp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   exp_t        q0[$];
   exp_t        q1[$];

   logic [31:0] in_data   [2];
   logic [3:0]  in_valid  [2];
   logic [3:0]  in_last   [2];
   logic [3:0]  in_ready  [2];
   logic [1:0]  sel       [2];
   logic [7:0]  out_data  [2];
   logic        out_last  [2];
   logic [1:0]  out_chan  [2];
   logic        out_valid [2];
   logic        out_ready [2];

   logic [23:0] c_data;
   logic [2:0]  c_valid, c_last, c_ready;
   logic [1:0]  c_sel, c_chan;
   logic [7:0]  c_out_data;
   logic        c_out_last, c_out_valid, c_out_ready;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   stream_mux #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_m0 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
      .in_last(in_last[0]), .in_ready(in_ready[0]), .select(sel[0]),
      .out_data(out_data[0]), .out_last(out_last[0]), .out_channel(out_chan[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]));

   stream_mux #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_m1 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
      .in_last(in_last[1]), .in_ready(in_ready[1]), .select(sel[1]),
      .out_data(out_data[1]), .out_last(out_last[1]), .out_channel(out_chan[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]));

   stream_mux #(.WIDTH(8), .CHANNELS(3), .MODE(0)) u_c3 (
      .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid),
      .in_last(c_last), .in_ready(c_ready), .select(c_sel),
      .out_data(c_out_data), .out_last(c_out_last), .out_channel(c_chan),
      .out_valid(c_out_valid), .out_ready(c_out_ready));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, expv, cyc);
      end
   endtask

   // One stimulus cycle on a 4-channel instance; ends at the negedge after checking in_ready.
   task automatic drive4(input int u, input logic [3:0] v, input logic [3:0] l,
                         input logic [31:0] d, input logic [1:0] s, input logic ordy,
                         input logic [3:0] exp_rdy, input bit lat, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      in_valid[u]  = v;
      in_last[u]   = l;
      in_data[u]   = d;
      sel[u]       = s;
      out_ready[u] = ordy;
      @(negedge clk);
      chk($sformatf("u%0d %s in_ready", u, tag), 32'(in_ready[u]), 32'(exp_rdy));
      for (int i = 0; i < 4; i++) begin
         if (v[i] && exp_rdy[i]) begin
            e.d     = d[i*8 +: 8];
            e.l     = l[i];
            e.ch    = 2'(i);
            e.stamp = lat ? cyc + 1 : 0;
            if (u == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
      end
   endtask

   // Scoreboard side: every consumed output beat is compared with the oldest expectation.
   always @(negedge clk) begin : mon
      exp_t e;
      for (int u = 0; u < 2; u++) begin
         if (out_valid[u] && out_ready[u]) begin
            if (u == 0 && q0.size() == 0) begin
               chk("u0 spurious beat, queue size", 32'(q0.size()), 32'd1);
            end else if (u == 1 && q1.size() == 0) begin
               chk("u1 spurious beat, queue size", 32'(q1.size()), 32'd1);
            end else begin
               if (u == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               chk($sformatf("u%0d out_data", u), 32'(out_data[u]), 32'(e.d));
               chk($sformatf("u%0d out_last", u), 32'(out_last[u]), 32'(e.l));
               chk($sformatf("u%0d out_channel", u), 32'(out_chan[u]), 32'(e.ch));
               if (e.stamp != 0) chk($sformatf("u%0d latency cycle", u), 32'(cyc), 32'(e.stamp));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         in_data[u] = 32'h0; in_valid[u] = 4'h0; in_last[u] = 4'h0;
         sel[u] = 2'd0; out_ready[u] = 1'b1;
      end
      c_data = 24'h0; c_valid = 3'b000; c_last = 3'b000; c_sel = 2'd0; c_out_ready = 1'b1;
      #12;
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("u%0d reset out_valid", u), 32'(out_valid[u]), 32'd0);
         chk($sformatf("u%0d reset out_data", u), 32'(out_data[u]), 32'd0);
         chk($sformatf("u%0d reset out_last", u), 32'(out_last[u]), 32'd0);
         chk($sformatf("u%0d reset out_channel", u), 32'(out_chan[u]), 32'd0);
      end
      chk("c3 reset out_valid", 32'(c_out_valid), 32'd0);
      rst_n = 1'b1;

      // External select: three-beat packet on channel 2.
      drive4(0, 4'b0100, 4'b0000, 32'h0011_0000, 2'd2, 1'b1, 4'b0100, 1'b1, "pkt b0");
      drive4(0, 4'b0100, 4'b0000, 32'h0022_0000, 2'd2, 1'b1, 4'b0100, 1'b1, "pkt b1");
      drive4(0, 4'b0100, 4'b0100, 32'h0033_0000, 2'd2, 1'b1, 4'b0100, 1'b1, "pkt b2");
      drive4(0, 4'b0000, 4'b0000, 32'h0000_0000, 2'd2, 1'b1, 4'b0100, 1'b1, "idle");

      // Select moves to channel 1 mid-packet; channel 2 keeps the lock until its last beat.
      drive4(0, 4'b0110, 4'b0000, 32'h0044_A100, 2'd2, 1'b1, 4'b0100, 1'b1, "lock b0");
      drive4(0, 4'b0110, 4'b0000, 32'h0055_A100, 2'd1, 1'b1, 4'b0100, 1'b1, "lock b1");
      drive4(0, 4'b0110, 4'b0100, 32'h0066_A100, 2'd1, 1'b1, 4'b0100, 1'b1, "lock b2");
      drive4(0, 4'b0010, 4'b0010, 32'h0000_A100, 2'd1, 1'b1, 4'b0010, 1'b1, "switch");
      drive4(0, 4'b0000, 4'b0000, 32'h0000_0000, 2'd1, 1'b1, 4'b0010, 1'b1, "idle2");

      // Backpressure: 0xA5 held for four stalled cycles, then consumed while 0x5A is accepted.
      drive4(0, 4'b0001, 4'b0001, 32'h0000_00A5, 2'd0, 1'b1, 4'b0001, 1'b0, "bp a5");
      for (int k = 0; k < 4; k++) begin
         drive4(0, 4'b0001, 4'b0001, 32'h0000_005A, 2'd0, 1'b0, 4'b0000, 1'b1, "bp stall");
         chk("bp out_data held", 32'(out_data[0]), 32'h0000_00A5);
         chk("bp out_valid held", 32'(out_valid[0]), 32'd1);
      end
      drive4(0, 4'b0001, 4'b0001, 32'h0000_005A, 2'd0, 1'b1, 4'b0001, 1'b1, "bp release");
      drive4(0, 4'b0000, 4'b0000, 32'h0000_0000, 2'd0, 1'b1, 4'b0001, 1'b1, "bp idle");

      // Round-robin with all channels valid, single-beat packets: order 0,1,2,3,0.
      drive4(1, 4'b1111, 4'b1111, 32'hB3B2_B1B0, 2'd0, 1'b1, 4'b0001, 1'b1, "rr g0");
      drive4(1, 4'b1111, 4'b1111, 32'hB3B2_B1B0, 2'd0, 1'b1, 4'b0010, 1'b1, "rr g1");
      drive4(1, 4'b1111, 4'b1111, 32'hB3B2_B1B0, 2'd0, 1'b1, 4'b0100, 1'b1, "rr g2");
      drive4(1, 4'b1111, 4'b1111, 32'hB3B2_B1B0, 2'd0, 1'b1, 4'b1000, 1'b1, "rr g3");
      drive4(1, 4'b1111, 4'b1111, 32'hC3C2_C1C0, 2'd0, 1'b1, 4'b0001, 1'b1, "rr g0 again");
      drive4(1, 4'b0000, 4'b0000, 32'h0000_0000, 2'd0, 1'b1, 4'b0000, 1'b1, "rr none");

      // Round-robin packet lock on channel 1, including a gap inside the packet.
      drive4(1, 4'b0110, 4'b0000, 32'h00D2_D100, 2'd0, 1'b1, 4'b0010, 1'b1, "rr lock b0");
      drive4(1, 4'b0100, 4'b0000, 32'h00D2_0000, 2'd0, 1'b1, 4'b0010, 1'b1, "rr lock gap");
      drive4(1, 4'b0110, 4'b0010, 32'h00D2_E100, 2'd0, 1'b1, 4'b0010, 1'b1, "rr lock b1");
      drive4(1, 4'b0100, 4'b0100, 32'h00D2_0000, 2'd0, 1'b1, 4'b0100, 1'b1, "rr next");
      drive4(1, 4'b0000, 4'b0000, 32'h0000_0000, 2'd0, 1'b1, 4'b0000, 1'b1, "rr idle");

      // Three channels, external select out of range: nothing granted.
      @(posedge clk);
      #1;
      c_sel = 2'd3; c_valid = 3'b111; c_last = 3'b111; c_data = 24'h03_02_01;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("c3 oor in_ready", 32'(c_ready), 32'd0);
         chk("c3 oor out_valid", 32'(c_out_valid), 32'd0);
         @(posedge clk);
         #1;
      end
      c_sel = 2'd2;
      @(negedge clk);
      chk("c3 sel2 in_ready", 32'(c_ready), 32'b100);
      @(posedge clk);
      #1;
      c_valid = 3'b000;
      @(negedge clk);
      chk("c3 out_valid", 32'(c_out_valid), 32'd1);
      chk("c3 out_data", 32'(c_out_data), 32'h03);
      chk("c3 out_channel", 32'(c_chan), 32'd2);
      chk("c3 out_last", 32'(c_out_last), 32'd1);

      // Asynchronous reset while channel 1 holds a packet lock with a beat in the output.
      drive4(1, 4'b0010, 4'b0000, 32'h0000_F100, 2'd0, 1'b1, 4'b0010, 1'b1, "pre-reset");
      drive4(1, 4'b0000, 4'b0000, 32'h0000_0000, 2'd0, 1'b0, 4'b0000, 1'b1, "pre-reset hold");
      chk("pre-reset out_valid", 32'(out_valid[1]), 32'd1);
      chk("pre-reset out_channel", 32'(out_chan[1]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async reset out_valid", 32'(out_valid[1]), 32'd0);
      chk("async reset out_data", 32'(out_data[1]), 32'd0);
      q1.delete();
      #2;
      rst_n = 1'b1;
      drive4(1, 4'b1111, 4'b1111, 32'hA3A2_A1A0, 2'd0, 1'b1, 4'b0001, 1'b1, "post-reset g0");
      drive4(1, 4'b0000, 4'b0000, 32'h0000_0000, 2'd0, 1'b1, 4'b0000, 1'b1, "post-reset idle");
      drive4(1, 4'b0000, 4'b0000, 32'h0000_0000, 2'd0, 1'b1, 4'b0000, 1'b1, "drain");

      chk("u0 scoreboard empty", 32'(q0.size()), 32'd0);
      chk("u1 scoreboard empty", 32'(q1.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
